// File: rtl/regfile_alu_sequencer_pkg.sv
// regfile_alu_sequencer_pkg: shared widths, op-codes and FSM encoding for the sequencer
package regfile_pkg;
  localparam int DATA_W = 18;
  localparam int ADDR_W = 4;
  localparam int NUM_REGS = 9;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE, ERR} state_e;
endpackage

// File: rtl/regfile_alu_sequencer_if.sv
// regfile_alu_sequencer_if: command handshake and register-file bus of the sequencer
interface regfile_alu_sequencer_if;
  import regfile_pkg::*;
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] rf_rs1;
  logic [ADDR_W-1:0] rf_rs2;
  logic [DATA_W-1:0] rf_rd1;
  logic [DATA_W-1:0] rf_rd2;
  logic [ADDR_W-1:0] rf_wa;
  logic [DATA_W-1:0] rf_wd;
  logic rf_wren;
  logic done;
  logic err;
  logic [DATA_W-1:0] result;
  logic cy;
  modport slave (
    input cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rf_rd1, rf_rd2,
    output cmd_ready, rf_rs1, rf_rs2, rf_wa, rf_wd, rf_wren, done, err, result, cy
  );
  modport master (
    output cmd_valid, cmd_op, cmd_rs1, cmd_rs2, cmd_rd, rf_rd1, rf_rd2,
    input cmd_ready, rf_rs1, rf_rs2, rf_wa, rf_wd, rf_wren, done, err, result, cy
  );
endinterface

// File: rtl/regfile_alu_sequencer_alu.sv
// rf_alu: combinational add/sub/and/xor with carry-out (add) or borrow (sub)
module rf_alu
  import regfile_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y,
  output logic              cy
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] dif;
  assign sum = {1'b0, a} + {1'b0, b};
  assign dif = {1'b0, a} - {1'b0, b};
  assign y = op == OP_ADD ? sum[DATA_W-1:0] : op == OP_SUB ? dif[DATA_W-1:0] : op == OP_AND ? a & b : a ^ b;
  assign cy = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? dif[DATA_W] : 1'b0;
endmodule

// File: rtl/regfile_alu_sequencer.sv
// regfile_alu_sequencer: read two registers, apply the ALU op, write the result back
module regfile_alu_sequencer
  import regfile_pkg::*;
(
  input logic clock,
  input logic reset,
  regfile_alu_sequencer_if.slave bus
);
  state_e state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [ADDR_W-1:0] rd_q, rd_d, rf_rs1_q, rf_rs1_d, rf_rs2_q, rf_rs2_d, rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, rf_wd_q, rf_wd_d, alu_y;
  logic cy_q, cy_d, done_q, done_d, err_q, err_d, alu_cy, illegal;
  rf_alu u_alu (.a(a_q), .b(b_q), .op(op_q), .y(alu_y), .cy(alu_cy));
  assign illegal = bus.cmd_rs1 >= ADDR_W'(NUM_REGS) || bus.cmd_rs2 >= ADDR_W'(NUM_REGS)
                || bus.cmd_rd >= ADDR_W'(NUM_REGS);
  assign bus.cmd_ready = state_q == IDLE;
  assign bus.rf_wren = state_q == WRITE && !reset;
  assign bus.rf_rs1 = rf_rs1_q;
  assign bus.rf_rs2 = rf_rs2_q;
  assign bus.rf_wa = rf_wa_q;
  assign bus.rf_wd = rf_wd_q;
  assign bus.done = done_q;
  assign bus.err = err_q;
  assign bus.result = result_q;
  assign bus.cy = cy_q;
  // Next-state and datapath: latch on accept, read selects only move for legal commands
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    rd_d = rd_q;
    rf_rs1_d = rf_rs1_q;
    rf_rs2_d = rf_rs2_q;
    rf_wa_d = rf_wa_q;
    rf_wd_d = rf_wd_q;
    a_d = a_q;
    b_d = b_q;
    result_d = result_q;
    cy_d = cy_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (bus.cmd_valid) begin
        op_d = bus.cmd_op;
        rd_d = bus.cmd_rd;
        state_d = illegal ? ERR : READ;
        rf_rs1_d = illegal ? rf_rs1_q : bus.cmd_rs1;
        rf_rs2_d = illegal ? rf_rs2_q : bus.cmd_rs2;
      end
      READ: begin
        a_d = bus.rf_rd1;
        b_d = bus.rf_rd2;
        state_d = EXEC;
      end
      EXEC: begin
        result_d = alu_y;
        cy_d = alu_cy;
        rf_wa_d = rd_q;
        rf_wd_d = alu_y;
        state_d = WRITE;
      end
      WRITE: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        done_d = 1'b1;
        err_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and output registers; reset drops any in-flight command without a done pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      rf_rs1_q <= '0;
      rf_rs2_q <= '0;
      rf_wa_q <= '0;
      rf_wd_q <= '0;
      a_q <= '0;
      b_q <= '0;
      result_q <= '0;
      cy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      rd_q <= rd_d;
      rf_rs1_q <= rf_rs1_d;
      rf_rs2_q <= rf_rs2_d;
      rf_wa_q <= rf_wa_d;
      rf_wd_q <= rf_wd_d;
      a_q <= a_d;
      b_q <= b_d;
      result_q <= result_d;
      cy_q <= cy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_regfile_alu_sequencer.sv
// tb_regfile_alu_sequencer: directed and randomized checks against a behavioural register-file model
module tb_regfile_alu_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int errors = 0;
  int checks = 0;
  regfile_alu_sequencer_if bus ();
  regfile_alu_sequencer dut (.clock(clock), .reset(reset), .bus(bus));
  always #5 clock = ~clock;

  logic [17:0] rf [16] = '{default: '0};
  logic [17:0] exp_rf [16] = '{default: '0};
  logic [17:0] exp_res = '0;
  logic exp_cy = 1'b0;
  logic bd_we = 1'b0;
  logic [3:0] bd_addr = '0;
  logic [17:0] bd_data = '0;

  assign bus.rf_rd1 = rf[bus.rf_rs1];
  assign bus.rf_rd2 = rf[bus.rf_rs2];
  always @(posedge clock) begin
    if (bus.rf_wren) rf[bus.rf_wa] <= bus.rf_wd;
    else if (bd_we) rf[bd_addr] <= bd_data;
  end

  int obs_wren_n, obs_wren_cyc, obs_done_cyc, obs_stall;
  logic [3:0] obs_wa;
  logic [17:0] obs_wd, obs_result;
  logic obs_err, obs_ready, obs_cy;

  function automatic logic [18:0] ref_alu(input logic [1:0] op, input logic [17:0] a, input logic [17:0] b);
    int unsigned ua = a;
    int unsigned ub = b;
    case (op)
      2'd0: return 19'(ua + ub);
      2'd1: return {ua < ub, 18'(ua + 262144 - ub)};
      2'd2: return {1'b0, a & b};
      default: return {1'b0, a ^ b};
    endcase
  endfunction

  task automatic seed(input logic [3:0] a, input logic [17:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clock);
    bd_we = 1'b0;
    exp_rf[a] = d;
  endtask

  task automatic scramble();
    bus.cmd_op = 2'($urandom_range(0, 3));
    bus.cmd_rs1 = 4'($urandom_range(0, 15));
    bus.cmd_rs2 = 4'($urandom_range(0, 15));
    bus.cmd_rd = 4'($urandom_range(0, 15));
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                        input logic [3:0] rd, input bit noise);
    obs_wren_n = 0; obs_wren_cyc = 0; obs_done_cyc = 0; obs_stall = 0;
    obs_wa = '0; obs_wd = '0; obs_result = '0; obs_err = 0; obs_ready = 0; obs_cy = 0;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2; bus.cmd_rd = rd;
    while (!bus.cmd_ready && obs_stall < 20) begin
      @(negedge clock);
      obs_stall++;
    end
    @(posedge clock);
    #1;
    if (noise) scramble(); else bus.cmd_valid = 1'b0;
    for (int k = 1; k <= 8 && obs_done_cyc == 0; k++) begin
      @(negedge clock);
      if (bus.rf_wren) begin obs_wren_n++; obs_wren_cyc = k; obs_wa = bus.rf_wa; obs_wd = bus.rf_wd; end
      if (bus.done) begin
        obs_done_cyc = k; obs_err = bus.err; obs_ready = bus.cmd_ready;
        obs_result = bus.result; obs_cy = bus.cy;
      end else if (noise) scramble();
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0; bus.cmd_rd = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.cmd_ready); end
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", bus.rf_wren); end
    checks++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin errors++; $display("FAIL reset_done_err got=%b%b exp=00", bus.done, bus.err); end
    checks++; if (bus.result !== 18'h0 || bus.cy !== 1'b0) begin errors++; $display("FAIL reset_result got=%h/%b exp=0/0", bus.result, bus.cy); end
    checks++; if ({bus.rf_rs1, bus.rf_rs2, bus.rf_wa} !== 12'h0) begin errors++; $display("FAIL reset_addrs got=%h exp=0", {bus.rf_rs1, bus.rf_rs2, bus.rf_wa}); end
    checks++; if (bus.rf_wd !== 18'h0) begin errors++; $display("FAIL reset_wd got=%h exp=0", bus.rf_wd); end
  endtask

  task automatic test_add_basic();
    seed(4'd1, 18'h00005);
    seed(4'd2, 18'h00003);
    do_cmd(2'b00, 4'd1, 4'd2, 4'd3, 1'b0);
    checks++; if (obs_wren_n !== 1 || obs_wren_cyc !== 3) begin errors++; $display("FAIL add_wren_timing got=n%0d/c%0d exp=n1/c3", obs_wren_n, obs_wren_cyc); end
    checks++; if (obs_wa !== 4'd3 || obs_wd !== 18'h00008) begin errors++; $display("FAIL add_write got=%h:%h exp=3:00008", obs_wa, obs_wd); end
    checks++; if (obs_done_cyc !== 4 || obs_err !== 1'b0) begin errors++; $display("FAIL add_done got=c%0d err%b exp=c4 err0", obs_done_cyc, obs_err); end
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL add_ready_at_done got=%b exp=1", obs_ready); end
    checks++; if (obs_result !== 18'h00008 || obs_cy !== 1'b0) begin errors++; $display("FAIL add_result got=%h/%b exp=00008/0", obs_result, obs_cy); end
    checks++; if (rf[3] !== 18'h00008) begin errors++; $display("FAIL add_rf3 got=%h exp=00008", rf[3]); end
    exp_rf[3] = 18'h00008; exp_res = 18'h00008; exp_cy = 1'b0;
  endtask

  task automatic test_carry_borrow();
    seed(4'd4, 18'h3FFFF);
    seed(4'd5, 18'h00001);
    do_cmd(2'b00, 4'd4, 4'd5, 4'd6, 1'b0);
    checks++; if (obs_wd !== 18'h0 || obs_cy !== 1'b1) begin errors++; $display("FAIL add_carry got=%h/%b exp=00000/1", obs_wd, obs_cy); end
    checks++; if (rf[6] !== 18'h0) begin errors++; $display("FAIL add_carry_rf6 got=%h exp=00000", rf[6]); end
    do_cmd(2'b01, 4'd5, 4'd4, 4'd7, 1'b0);
    checks++; if (obs_wd !== 18'h00002 || obs_cy !== 1'b1) begin errors++; $display("FAIL sub_borrow got=%h/%b exp=00002/1", obs_wd, obs_cy); end
    checks++; if (rf[7] !== 18'h00002) begin errors++; $display("FAIL sub_rf7 got=%h exp=00002", rf[7]); end
    exp_rf[6] = 18'h0; exp_rf[7] = 18'h00002; exp_res = 18'h00002; exp_cy = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_cmd(2'b10, 4'd1, 4'd2, 4'd8, 1'b0);
    checks++; if (obs_wd !== 18'h00001 || obs_done_cyc !== 4) begin errors++; $display("FAIL b2b_and got=%h c%0d exp=00001 c4", obs_wd, obs_done_cyc); end
    do_cmd(2'b11, 4'd8, 4'd1, 4'd0, 1'b0);
    checks++; if (obs_stall !== 0) begin errors++; $display("FAIL b2b_stall got=%0d exp=0", obs_stall); end
    checks++; if (obs_wd !== 18'h00004 || obs_done_cyc !== 4) begin errors++; $display("FAIL b2b_xor got=%h c%0d exp=00004 c4", obs_wd, obs_done_cyc); end
    checks++; if (rf[0] !== 18'h00004 || rf[8] !== 18'h00001) begin errors++; $display("FAIL b2b_rf got=%h,%h exp=00004,00001", rf[0], rf[8]); end
    exp_rf[8] = 18'h00001; exp_rf[0] = 18'h00004; exp_res = 18'h00004; exp_cy = 1'b0;
  endtask

  task automatic test_illegal();
    do_cmd(2'b00, 4'd1, 4'd2, 4'd9, 1'b0);
    checks++; if (obs_wren_n !== 0) begin errors++; $display("FAIL ill_rd_wren got=%0d exp=0", obs_wren_n); end
    checks++; if (obs_done_cyc !== 2 || obs_err !== 1'b1) begin errors++; $display("FAIL ill_rd_done got=c%0d err%b exp=c2 err1", obs_done_cyc, obs_err); end
    checks++; if (obs_result !== exp_res || obs_cy !== exp_cy) begin errors++; $display("FAIL ill_rd_result got=%h/%b exp=%h/%b", obs_result, obs_cy, exp_res, exp_cy); end
    do_cmd(2'b01, 4'd15, 4'd2, 4'd3, 1'b0);
    checks++; if (obs_wren_n !== 0 || obs_done_cyc !== 2 || obs_err !== 1'b1) begin errors++; $display("FAIL ill_rs1 got=n%0d c%0d err%b exp=n0 c2 err1", obs_wren_n, obs_done_cyc, obs_err); end
    checks++; if (rf[3] !== exp_rf[3]) begin errors++; $display("FAIL ill_rf3 got=%h exp=%h", rf[3], exp_rf[3]); end
  endtask

  task automatic test_reset_in_write();
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_rs1 = 4'd1; bus.cmd_rs2 = 4'd2; bus.cmd_rd = 4'd5;
    @(posedge clock);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (bus.rf_wren !== 1'b1) begin errors++; $display("FAIL rstw_pre_wren got=%b exp=1", bus.rf_wren); end
    reset = 1'b1;
    #1;
    checks++; if (bus.rf_wren !== 1'b0) begin errors++; $display("FAIL rstw_wren got=%b exp=0", bus.rf_wren); end
    @(negedge clock);
    reset = 1'b0;
    checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rstw_after got=done%b ready%b exp=done0 ready1", bus.done, bus.cmd_ready); end
    checks++; if (rf[5] !== exp_rf[5]) begin errors++; $display("FAIL rstw_rf5 got=%h exp=%h", rf[5], exp_rf[5]); end
    @(negedge clock);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rstw_late_done got=%b exp=0", bus.done); end
    exp_res = '0; exp_cy = 1'b0;
  endtask

  task automatic test_hold_noise();
    do_cmd(2'b01, 4'd2, 4'd1, 4'd4, 1'b1);
    checks++; if (obs_wa !== 4'd4 || obs_wd !== 18'h3FFFE || obs_cy !== 1'b1) begin errors++; $display("FAIL noise_write got=%h:%h/%b exp=4:3fffe/1", obs_wa, obs_wd, obs_cy); end
    checks++; if (obs_done_cyc !== 4 || obs_wren_n !== 1) begin errors++; $display("FAIL noise_timing got=c%0d n%0d exp=c4 n1", obs_done_cyc, obs_wren_n); end
    exp_rf[4] = 18'h3FFFE; exp_res = 18'h3FFFE; exp_cy = 1'b1;
    @(negedge clock);
    checks++; if (bus.done !== 1'b0 || bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL noise_idle got=done%b ready%b exp=done0 ready1", bus.done, bus.cmd_ready); end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [3:0] rs1, rs2, rd;
    logic [18:0] e;
    bit bad;
    for (int i = 0; i < 9; i++) seed(4'(i), 18'($urandom));
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      rs1 = 4'($urandom_range(0, 8));
      rs2 = 4'($urandom_range(0, 8));
      rd = 4'($urandom_range(0, 8));
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 2))
          0: rs1 = 4'($urandom_range(9, 15));
          1: rs2 = 4'($urandom_range(9, 15));
          default: rd = 4'($urandom_range(9, 15));
        endcase
      end
      bad = rs1 > 8 || rs2 > 8 || rd > 8;
      e = ref_alu(op, exp_rf[rs1], exp_rf[rs2]);
      if (!bad) begin exp_res = e[17:0]; exp_cy = e[18]; end
      do_cmd(op, rs1, rs2, rd, bit'(i % 2));
      checks++; if (obs_done_cyc !== (bad ? 2 : 4) || obs_err !== bad) begin errors++; $display("FAIL rnd%0d_done got=c%0d err%b exp=c%0d err%b", i, obs_done_cyc, obs_err, bad ? 2 : 4, bad); end
      checks++; if (obs_result !== exp_res || obs_cy !== exp_cy) begin errors++; $display("FAIL rnd%0d_result got=%h/%b exp=%h/%b", i, obs_result, obs_cy, exp_res, exp_cy); end
      checks++; if (obs_wren_n !== (bad ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_wren got=%0d exp=%0d", i, obs_wren_n, bad ? 0 : 1); end
      if (!bad) begin
        exp_rf[rd] = exp_res;
        checks++; if (obs_wa !== rd || rf[rd] !== exp_res) begin errors++; $display("FAIL rnd%0d_rf got=%h:%h exp=%h:%h", i, obs_wa, rf[rd], rd, exp_res); end
      end
    end
    for (int r = 0; r < 9; r++) begin
      checks++; if (rf[r] !== exp_rf[r]) begin errors++; $display("FAIL rnd_final_r%0d got=%h exp=%h", r, rf[r], exp_rf[r]); end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_carry_borrow();
    test_back_to_back();
    test_illegal();
    test_reset_in_write();
    test_hold_noise();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
